// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame controller, line buffers and 3x3 window for a Sobel stage
// Optional: define SOBEL_CTRL_PERF_EN to add the cyc_cnt busy-cycle counter port.
module sobel_frame_ctrl #(
  parameter int MAX_W = 640,
  parameter int DIM_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [71:0]      win,
  output logic             win_valid,
  output logic [DIM_W-1:0] win_x,
  output logic [DIM_W-1:0] win_y,
  input  logic             sob_valid,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef SOBEL_CTRL_PERF_EN
  ,
  output logic [31:0]      cyc_cnt
`endif
);

  localparam int CW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE = DIM_W'(3);
  localparam logic [DIM_W:0]   MAX_V = (DIM_W+1)'(MAX_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [DIM_W-1:0] w_q, h_q, x, y;
  logic [CW-1:0]    res_cnt, res_nxt, res_total;
  logic             cfg_ok, start_ok, accept, x_last, last_px, win_hit;
  logic [23:0]      col_new, col_m1, col_m2;
  logic [71:0]      win_nxt;
  logic [7:0]       lb0 [MAX_W];
  logic [7:0]       lb1 [MAX_W];

  assign cfg_ok    = (cfg_w >= THREE) && ({1'b0, cfg_w} <= MAX_V) && (cfg_h >= THREE);
  assign start_ok  = start && !abort && (state == IDLE) && cfg_ok;
  assign s_ready   = (state == RUN) && !abort;
  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign x_last    = (x == w_q - ONE);
  assign last_px   = x_last && (y == h_q - ONE);
  assign win_hit   = (x >= TWO) && (y >= TWO);
  assign res_total = CW'(w_q - TWO) * CW'(h_q - TWO);
  assign res_nxt   = res_cnt + CW'(sob_valid && (state != IDLE));

  // Column layout {row y, row y-1, row y-2}; line buffers hold the two rows above.
  assign col_new = {s_data, lb0[x], lb1[x]};
  assign win_nxt = {col_new[23:16], col_m1[23:16], col_m2[23:16],
                    col_new[15:8],  col_m1[15:8],  col_m2[15:8],
                    col_new[7:0],   col_m1[7:0],   col_m2[7:0]};

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = RUN;
        RUN:     if (accept && last_px) state_nxt = DRAIN;
        DRAIN: begin
          if (res_nxt == res_total) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x         <= '0;
      y         <= '0;
      res_cnt   <= '0;
      col_m1    <= '0;
      col_m2    <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      err       <= start && !abort && (state == IDLE) && !cfg_ok;
      win_valid <= 1'b0;
      if (start_ok) begin
        w_q     <= cfg_w;
        h_q     <= cfg_h;
        x       <= '0;
        y       <= '0;
        res_cnt <= '0;
      end else begin
        res_cnt <= res_nxt;
      end
      if (accept) begin
        col_m2 <= col_m1;
        col_m1 <= col_new;
        if (x_last) begin
          x <= '0;
          y <= y + ONE;
        end else begin
          x <= x + ONE;
        end
        if (win_hit) begin
          win       <= win_nxt;
          win_valid <= 1'b1;
          win_x     <= x - ONE;
          win_y     <= y - ONE;
        end
      end
    end
  end

  // Line-buffer contents are only read once the rows above were written this frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[x] <= s_data;
      lb1[x] <= lb0[x];
    end
  end

`ifdef SOBEL_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (start_ok) begin
      cyc_cnt <= '0;
    end else if (busy && (cyc_cnt != '1)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - self-checking bench for sobel_frame_ctrl with a 2-cycle Sobel model
module tb_sobel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  cfg_w = '0;
  logic [9:0]  cfg_h = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic [71:0] win;
  logic        win_valid;
  logic [9:0]  win_x, win_y;
  logic        sob_valid;
  logic        busy, done, err;
`ifdef SOBEL_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
`endif

  sobel_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .win(win), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .sob_valid(sob_valid),
    .busy(busy), .done(done), .err(err)
`ifdef SOBEL_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Sobel stage stand-in: fixed two-cycle latency from win_valid to sob_valid.
  logic [1:0] sob_pipe = '0;
  always @(posedge clk) sob_pipe <= {sob_pipe[0], win_valid};
  assign sob_valid = sob_pipe[1];

  typedef struct {
    logic [71:0] win;
    logic [9:0]  x;
    logic [9:0]  y;
  } win_t;

  typedef struct {
    logic [9:0] w;
    logic [9:0] h;
    bit         exp_err;
  } cfg_vec_t;

  win_t       exp_q[$];
  logic [7:0] img[64];
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, busy_cyc = 0, win_cnt = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid) begin
        win_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got x=%0d y=%0d expected none", win_x, win_y);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          if (win !== e.win || win_x !== e.x || win_y !== e.y) begin
            errors++;
            $display("FAIL window: got %0h (%0d,%0d) expected %0h (%0d,%0d)",
                     win, win_x, win_y, e.win, e.x, e.y);
          end
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (!sob_valid) begin
          errors++;
          $display("FAIL done_vs_sob: got sob_valid=0 expected 1");
        end
      end
      if (err) err_cnt++;
      if (busy) busy_cyc++;
    end
  end

  task automatic run_frame(input int w, input int h, input bit rnd,
                           input int abort_at, input int restart_at);
    int idx, cyc, d0, e0, w0, n;
    n = w * h;
    for (int i = 0; i < n; i++) img[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
    exp_q.delete();
    for (int yy = 1; yy <= h - 2; yy++)
      for (int xx = 1; xx <= w - 2; xx++) begin
        win_t e;
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[(r*3+c)*8 +: 8] = img[(yy-1+r)*w + (xx-1+c)];
        e.x = 10'(xx);
        e.y = 10'(yy);
        exp_q.push_back(e);
      end
    d0 = done_cnt; e0 = err_cnt; w0 = win_cnt;
    @(posedge clk); #1;
    cfg_w = 10'(w); cfg_h = 10'(h); start = 1'b1; busy_cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 2000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = img[idx];
      if (idx == restart_at) begin start = 1'b1; cfg_w = 10'd2; end
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      start = 1'b0; cyc++;
      if (abort_at > 0 && idx == abort_at) break;
    end
    s_valid = 1'b0;
    check("stream_timeout", 72'(cyc < 2000), 72'(1));
    if (abort_at > 0) begin
      abort = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      check("abort_cycle_s_ready", 72'(s_ready), 72'(0));
      @(posedge clk); #1;
      abort = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", 72'(busy), 72'(0));
      check("abort_s_ready", 72'(s_ready), 72'(0));
      check("abort_win_valid", 72'(win_valid), 72'(0));
      repeat (6) @(posedge clk);
      check("abort_no_done", 72'(done_cnt), 72'(d0));
      exp_q.delete();
    end else begin
      for (int k = 0; k < 64; k++) begin
        @(posedge clk);
        if (done_cnt > d0) break;
      end
      #1;
      check("busy_after_done", 72'(busy), 72'(0));
      repeat (4) @(posedge clk);
      check("done_count", 72'(done_cnt), 72'(d0 + 1));
      check("window_count", 72'(win_cnt - w0), 72'((w - 2) * (h - 2)));
      check("windows_left", 72'(exp_q.size()), 72'(0));
      check("no_err", 72'(err_cnt), 72'(e0));
    end
  endtask

  initial begin
    cfg_vec_t vecs[6];
    vecs[0] = '{10'd2,   10'd3, 1'b1};
    vecs[1] = '{10'd3,   10'd2, 1'b1};
    vecs[2] = '{10'd641, 10'd5, 1'b1};
    vecs[3] = '{10'd0,   10'd0, 1'b1};
    vecs[4] = '{10'd3,   10'd3, 1'b0};
    vecs[5] = '{10'd640, 10'd3, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_s_ready", 72'(s_ready), 72'(0));
    check("rst_win_valid", 72'(win_valid), 72'(0));
    check("rst_done_err", 72'({done, err}), 72'(0));
    check("rst_win", win, 72'(0));
    check("rst_win_xy", 72'({win_x, win_y}), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cfg_w = vecs[i].w; cfg_h = vecs[i].h; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d_err", i), 72'(err), 72'(vecs[i].exp_err));
      check($sformatf("cfg%0d_busy", i), 72'(busy), 72'(!vecs[i].exp_err));
      check($sformatf("cfg%0d_s_ready", i), 72'(s_ready), 72'(!vecs[i].exp_err));
      @(negedge clk);
      check($sformatf("cfg%0d_err_pulse", i), 72'(err), 72'(0));
      if (!vecs[i].exp_err) begin
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
      end
    end

    run_frame(4, 3, 1'b0, 0, -1);
`ifdef SOBEL_CTRL_PERF_EN
    check("cyc_cnt", 72'(cyc_cnt), 72'(busy_cyc));
`endif
    run_frame(8, 8, 1'b1, 0, -1);
    run_frame(8, 8, 1'b0, 20, -1);
    run_frame(4, 3, 1'b0, 0, -1);
    run_frame(4, 3, 1'b0, 0, 5);
    run_frame(5, 4, 1'b1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
